xdma_reqrsp_to_axi_write: RTL and testbench
===========================================

Name: xdma_reqrsp_to_axi_write

Overview:
Reqrsp-to-AXI4 write master for the XDMA data path, the initiator-side counterpart of the AXI-to-reqrsp write adapter.
- Collects posted reqrsp write beats with contiguous addresses into a burst buffer.
- Issues each buffered run as one AXI INCR burst (AW then W) and consumes B responses.
- Sits between the XDMA streaming engine and the system AXI crossbar.

Parameters:
axi_out_req_t, logic, AXI4 request type (master side).
axi_out_resp_t, logic, AXI4 response type.
reqrsp_req_t / reqrsp_rsp_t, logic, reqrsp channel types (addr, write, amo, data, strb, size, q_valid, p_ready / q_ready, p_valid, data, error).
addr_t / data_t / strb_t / axi_id_t, logic, field types.
MaxBurstLen, 16, maximum beats per AXI burst, power of two, ≤256.
MaxOutstanding, 4, maximum AW bursts awaiting B.
TimeoutCycles, 16, idle cycles before a partial burst is flushed.
AxiId, 0, constant AW id.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
reqrsp_req_i  in  reqrsp_req_t  reqrsp request channel (this block is responder)
reqrsp_rsp_o  out  reqrsp_rsp_t  reqrsp response channel
axi_req_o  out  axi_out_req_t  AXI master request
axi_rsp_i  in  axi_out_resp_t  AXI master response
clear_error_i  in  1  clears error_o
busy_o  out  1  buffer non-empty, AW/W in flight, or outstanding>0
error_o  out  1  sticky: some B resp != OKAY

Behaviour:
- Reset: state=FILL, cnt=0, outstanding=0, idle=0, error_o=0, all AXI valids=0, p_valid=0.
- AR/R tied off: ar_valid=0, r_ready=0. b_ready=1 always.
- FSM states: FILL, AW, W.
- FILL, write beat (q_valid & write): q_ready=1 only if all of the following hold:
  - cnt<MaxBurstLen;
  - outstanding<MaxOutstanding;
  - the beat is compatible.
- Compatible means:
  - cnt==0; or
  - size==size_q, addr==base_q+cnt·2^size_q, and that address is not 4KiB-aligned.
- On accept:
  - push data/strb into buffer;
  - if cnt==0, latch base_q=addr aligned to size, and size_q;
  - cnt++, idle=0.
- FILL, incompatible beat with cnt>0: q_ready=0, next state AW. The beat is accepted later as the first beat of a new run.
- Accept that makes cnt==MaxBurstLen: next state AW.
- Timeout: in FILL with cnt>0 and no accept, idle++. When idle==TimeoutCycles-1, next state AW.
- Reads (write=0) in FILL: q_ready=1, and the next cycle p_valid=1, error=1, data=0. Writes are posted and produce no p response.
- AW state:
  - aw_valid=1; addr=base_q, len=cnt-1, size=size_q, burst=INCR, id=AxiId, cache/prot/qos/lock/atop=0.
  - On aw_ready: outstanding++, rd=0, next state W.
  - aw_valid holds with stable payload until ready.
- W state:
  - w_valid=1, data/strb=buffer[rd], last=(rd==cnt-1).
  - On handshake: rd++, pop.
  - On the last handshake: cnt=0, idle=0, next state FILL.
- The buffer is not written while in AW/W (q_ready=0).
- B: on b_valid, outstanding--. Simultaneous AW handshake and B gives net 0. If resp!=OKAY, set error_o.
- clear_error_i clears error_o. If clear and set occur in the same cycle, set wins.
- Widths: cnt and rd are $clog2(MaxBurstLen)+1 bits; outstanding is $clog2(MaxOutstanding)+1 bits.
- Address arithmetic is in addr_t and wraps modulo 2^|addr_t|. The 4KiB rule prevents bursts from crossing a page.
- Reset mid-burst aborts the burst immediately; buffered data is discarded.

Decomposition:
- xdma_pkg holds:
  - the state enum (FILL/AW/W);
  - constant AxiBurstIncr;
  - constant Page4k=12.
- Natural sub-module: the burst buffer, built with common_cells fifo_v3 (DEPTH=MaxBurstLen, data={data_t,strb_t}), pushed on accept and popped on W handshake.

Test Plan:
- 16 contiguous 64-bit writes from 0x1000, size=3, aw_ready/w_ready=1 -> one AW (addr 0x1000, len 15, size 3), 16 W beats, last on beat 16, busy_o low after B.
- 3 beats at 0x2000/0x2008/0x2010, then a beat at 0x3000 -> AW len=2 at 0x2000 first, then the 0x3000 beat starts a new run.
- Beats 0x0FF0, 0x0FF8, 0x1000 -> AW len=1 at 0x0FF0, then a separate burst at 0x1000 (no 4KiB crossing).
- Single beat then 16 idle cycles -> AW len=0 issued at timeout; aw_ready held low 5 cycles -> payload stable.
- Five 1-beat flushes with b_valid withheld -> the fifth AW is not issued (q_ready=0) until one B returns; B resp=SLVERR -> error_o=1 until clear_error_i.
- Read request -> p_valid=1, error=1 one cycle after accept; reset asserted during W -> all valids 0, cnt 0, busy_o 0.

Source files
------------

// File: rtl/xdma_pkg.sv
// Shared types and constants for the XDMA reqrsp-to-AXI write master.
// The struct types are the default channel types used by the top module.
package xdma_pkg;

    typedef enum logic [1:0] {
        StFill = 2'd0,
        StAw   = 2'd1,
        StW    = 2'd2
    } xdma_wr_state_e;

    localparam logic [1:0]  AxiBurstIncr = 2'b01;
    localparam logic [1:0]  AxiRespOkay  = 2'b00;
    localparam int unsigned Page4k       = 12;

    typedef logic [31:0] xdma_addr_t;
    typedef logic [63:0] xdma_data_t;
    typedef logic [7:0]  xdma_strb_t;
    typedef logic [1:0]  xdma_id_t;

    typedef struct packed {
        xdma_addr_t addr;
        logic       write;
        logic [3:0] amo;
        xdma_data_t data;
        xdma_strb_t strb;
        logic [2:0] size;
    } xdma_reqrsp_q_t;

    typedef struct packed {
        xdma_reqrsp_q_t q;
        logic           q_valid;
        logic           p_ready;
    } xdma_reqrsp_req_t;

    typedef struct packed {
        xdma_data_t data;
        logic       error;
    } xdma_reqrsp_p_t;

    typedef struct packed {
        xdma_reqrsp_p_t p;
        logic           p_valid;
        logic           q_ready;
    } xdma_reqrsp_rsp_t;

    typedef struct packed {
        xdma_id_t   id;
        xdma_addr_t addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [5:0] atop;
    } xdma_axi_ax_t;

    typedef struct packed {
        xdma_data_t data;
        xdma_strb_t strb;
        logic       last;
    } xdma_axi_w_t;

    typedef struct packed {
        xdma_id_t   id;
        logic [1:0] resp;
    } xdma_axi_b_t;

    typedef struct packed {
        xdma_id_t   id;
        xdma_data_t data;
        logic [1:0] resp;
        logic       last;
    } xdma_axi_r_t;

    typedef struct packed {
        xdma_axi_ax_t aw;
        logic         aw_valid;
        xdma_axi_w_t  w;
        logic         w_valid;
        logic         b_ready;
        xdma_axi_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } xdma_axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        xdma_axi_b_t b;
        logic        b_valid;
        logic        ar_ready;
        xdma_axi_r_t r;
        logic        r_valid;
    } xdma_axi_resp_t;

endpackage

// File: rtl/xdma_reqrsp_to_axi_write_buf.sv
// Burst buffer: power-of-two circular FIFO holding {data, strb} for one run.
// Occupancy is bounded by the owner's beat counter, so no full/empty flags are needed.
module xdma_reqrsp_to_axi_write_buf #(
    parameter int unsigned Width = 72,
    parameter int unsigned Depth = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [Width-1:0] mem_q [Depth];

    // Pointer advance on push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) begin
            wptr_d = wptr_q + PtrW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_i) begin
            rptr_d = rptr_q + PtrW'(1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers; reset discards any buffered beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= PtrW'(0);
            rptr_q <= PtrW'(0);
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array, written only on push.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o = mem_q[rptr_q];

endmodule

// File: rtl/xdma_reqrsp_to_axi_write.sv
// Reqrsp-to-AXI4 write master: gathers contiguous posted write beats into a buffer
// and issues each run as one INCR burst (AW then W), tracking outstanding B responses.
module xdma_reqrsp_to_axi_write
    import xdma_pkg::*;
#(
    parameter type axi_out_req_t  = xdma_axi_req_t,
    parameter type axi_out_resp_t = xdma_axi_resp_t,
    parameter type reqrsp_req_t   = xdma_reqrsp_req_t,
    parameter type reqrsp_rsp_t   = xdma_reqrsp_rsp_t,
    parameter type addr_t         = xdma_addr_t,
    parameter type data_t         = xdma_data_t,
    parameter type strb_t         = xdma_strb_t,
    parameter type axi_id_t       = xdma_id_t,
    parameter int unsigned MaxBurstLen    = 16,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 16,
    parameter axi_id_t     AxiId          = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  reqrsp_req_t   reqrsp_req_i,
    output reqrsp_rsp_t   reqrsp_rsp_o,
    output axi_out_req_t  axi_req_o,
    input  axi_out_resp_t axi_rsp_i,
    input  logic          clear_error_i,
    output logic          busy_o,
    output logic          error_o
);

    localparam int unsigned CntW  = $clog2(MaxBurstLen) + 1;
    localparam int unsigned OutW  = $clog2(MaxOutstanding) + 1;
    localparam int unsigned IdleW = $clog2(TimeoutCycles) + 1;
    localparam int unsigned BufW  = $bits(data_t) + $bits(strb_t);

    localparam logic [CntW-1:0]  MaxCnt      = CntW'(MaxBurstLen);
    localparam logic [OutW-1:0]  MaxOut      = OutW'(MaxOutstanding);
    localparam logic [IdleW-1:0] TimeoutLast = IdleW'(TimeoutCycles - 1);

    xdma_wr_state_e   state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  rd_q, rd_d;
    logic [OutW-1:0]  out_q, out_d;
    logic [IdleW-1:0] idle_q, idle_d;
    addr_t            base_q, base_d;
    logic [2:0]       size_q, size_d;
    logic             error_q, error_d;
    logic             p_valid_q, p_valid_d;

    logic        q_ready_s, wr_acc_s, rd_acc_s, compatible_s;
    logic        push_s, pop_s, aw_hs_s, b_dec_s, w_last_s;
    addr_t       next_addr_s;
    logic [BufW-1:0] buf_wdata_s, buf_rdata_s;
    logic        unused_inputs;

    function automatic addr_t align_addr(addr_t addr, logic [2:0] size);
        return addr & ~((addr_t'(1) << size) - addr_t'(1));
    endfunction

    assign buf_wdata_s = {reqrsp_req_i.q.data, reqrsp_req_i.q.strb};
    assign next_addr_s = base_q + (addr_t'(cnt_q) << size_q);
    assign w_last_s    = (rd_q == (cnt_q - CntW'(1)));

    // A beat may extend the run only at the next contiguous address and never onto a new 4KiB page.
    assign compatible_s = (cnt_q == CntW'(0)) ||
                          ((reqrsp_req_i.q.size == size_q) &&
                           (reqrsp_req_i.q.addr == next_addr_s) &&
                           (|reqrsp_req_i.q.addr[Page4k-1:0]));

    xdma_reqrsp_to_axi_write_buf #(
        .Width (BufW),
        .Depth (MaxBurstLen)
    ) i_buf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push_s),
        .data_i (buf_wdata_s),
        .pop_i  (pop_s),
        .data_o (buf_rdata_s)
    );

    // Burst FSM: fill, flush decisions, AW issue and W streaming.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        idle_d    = idle_q;
        base_d    = base_q;
        size_d    = size_q;
        q_ready_s = 1'b0;
        wr_acc_s  = 1'b0;
        rd_acc_s  = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        aw_hs_s   = 1'b0;
        case (state_q)
            StFill: begin
                if (reqrsp_req_i.q_valid && reqrsp_req_i.q.write) begin
                    if (compatible_s && (cnt_q < MaxCnt) && (out_q < MaxOut)) begin
                        q_ready_s = 1'b1;
                        wr_acc_s  = 1'b1;
                    end else if (!compatible_s) begin
                        state_d = StAw;
                    end else begin
                        state_d = StFill;
                    end
                end else if (reqrsp_req_i.q_valid) begin
                    // A read may only be taken once the previous error response has drained.
                    q_ready_s = !(p_valid_q && !reqrsp_req_i.p_ready);
                    rd_acc_s  = q_ready_s;
                end else begin
                    q_ready_s = 1'b0;
                end
                if (wr_acc_s) begin
                    push_s = 1'b1;
                    if (cnt_q == CntW'(0)) begin
                        base_d = align_addr(reqrsp_req_i.q.addr, reqrsp_req_i.q.size);
                        size_d = reqrsp_req_i.q.size;
                    end else begin
                        base_d = base_q;
                    end
                    cnt_d  = cnt_q + CntW'(1);
                    idle_d = IdleW'(0);
                    if (cnt_d == MaxCnt) begin
                        state_d = StAw;
                    end else begin
                        state_d = StFill;
                    end
                end else if ((cnt_q != CntW'(0)) && (state_d == StFill)) begin
                    if (idle_q == TimeoutLast) begin
                        state_d = StAw;
                    end else begin
                        idle_d = idle_q + IdleW'(1);
                    end
                end else begin
                    idle_d = idle_q;
                end
            end
            StAw: begin
                if (axi_rsp_i.aw_ready) begin
                    aw_hs_s = 1'b1;
                    rd_d    = CntW'(0);
                    state_d = StW;
                end else begin
                    state_d = StAw;
                end
            end
            StW: begin
                if (axi_rsp_i.w_ready) begin
                    pop_s = 1'b1;
                    rd_d  = rd_q + CntW'(1);
                    if (w_last_s) begin
                        cnt_d   = CntW'(0);
                        idle_d  = IdleW'(0);
                        state_d = StFill;
                    end else begin
                        state_d = StW;
                    end
                end else begin
                    state_d = StW;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    // Outstanding-burst count, sticky error flag and read error response.
    always_comb begin
        b_dec_s = axi_rsp_i.b_valid && (out_q != OutW'(0));
        case ({aw_hs_s, b_dec_s})
            2'b10:   out_d = out_q + OutW'(1);
            2'b01:   out_d = out_q - OutW'(1);
            default: out_d = out_q;
        endcase
        if (axi_rsp_i.b_valid && (axi_rsp_i.b.resp != AxiRespOkay)) begin
            error_d = 1'b1;
        end else if (clear_error_i) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
        p_valid_d = rd_acc_s || (p_valid_q && !reqrsp_req_i.p_ready);
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StFill;
            cnt_q     <= CntW'(0);
            rd_q      <= CntW'(0);
            out_q     <= OutW'(0);
            idle_q    <= IdleW'(0);
            base_q    <= addr_t'(0);
            size_q    <= 3'd0;
            error_q   <= 1'b0;
            p_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            out_q     <= out_d;
            idle_q    <= idle_d;
            base_q    <= base_d;
            size_q    <= size_d;
            error_q   <= error_d;
            p_valid_q <= p_valid_d;
        end
    end

    // Channel output assembly; AR/R are tied off and B is always accepted.
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw_valid = (state_q == StAw);
        axi_req_o.aw.id    = AxiId;
        axi_req_o.aw.addr  = base_q;
        axi_req_o.aw.len   = 8'(cnt_q - CntW'(1));
        axi_req_o.aw.size  = size_q;
        axi_req_o.aw.burst = AxiBurstIncr;
        axi_req_o.w_valid  = (state_q == StW);
        axi_req_o.w.data   = buf_rdata_s[BufW-1:$bits(strb_t)];
        axi_req_o.w.strb   = buf_rdata_s[$bits(strb_t)-1:0];
        axi_req_o.w.last   = w_last_s;
        axi_req_o.b_ready  = 1'b1;

        reqrsp_rsp_o         = '0;
        reqrsp_rsp_o.q_ready = q_ready_s;
        reqrsp_rsp_o.p_valid = p_valid_q;
        reqrsp_rsp_o.p.error = 1'b1;
    end

    assign busy_o  = (cnt_q != CntW'(0)) || (state_q != StFill) || (out_q != OutW'(0));
    assign error_o = error_q;

    assign unused_inputs = ^{reqrsp_req_i.q.amo, axi_rsp_i.b.id, axi_rsp_i.ar_ready,
                             axi_rsp_i.r, axi_rsp_i.r_valid};

endmodule

// File: tb/tb_xdma_reqrsp_to_axi_write.sv
// Scoreboard bench for xdma_reqrsp_to_axi_write: directed write runs, flush rules,
// outstanding limit, error handling, read error response and mid-burst reset.
module tb_xdma_reqrsp_to_axi_write;
    import xdma_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xdma_reqrsp_req_t req;
    xdma_reqrsp_rsp_t rsp;
    xdma_axi_req_t    axi_req;
    xdma_axi_resp_t   axi_rsp;
    logic             clear_err;
    logic             busy;
    logic             err;

    logic       aw_ready_tb = 1'b1;
    logic       w_ready_tb  = 1'b1;
    logic       b_valid_tb  = 1'b0;
    logic [1:0] b_resp_tb   = 2'b00;
    logic [1:0] b_resp_sel  = 2'b00;
    int         aw_cnt  = 0;
    int         b_sent  = 0;
    int         b_allow = 1000000;

    always_comb begin
        axi_rsp          = '0;
        axi_rsp.aw_ready = aw_ready_tb;
        axi_rsp.w_ready  = w_ready_tb;
        axi_rsp.b_valid  = b_valid_tb;
        axi_rsp.b.resp   = b_resp_tb;
    end

    xdma_reqrsp_to_axi_write #(
        .MaxBurstLen    (16),
        .MaxOutstanding (4),
        .TimeoutCycles  (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .reqrsp_req_i  (req),
        .reqrsp_rsp_o  (rsp),
        .axi_req_o     (axi_req),
        .axi_rsp_i     (axi_rsp),
        .clear_error_i (clear_err),
        .busy_o        (busy),
        .error_o       (err)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; } aw_exp_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_exp_t;
    aw_exp_t     exp_aw[$];
    w_exp_t      exp_w[$];
    logic [64:0] exp_p[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Monitor: compares every presented AW/W/P payload against the front of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi_req.ar_valid !== 1'b0 || axi_req.r_ready !== 1'b0 || axi_req.b_ready !== 1'b1)
                check("tieoff", {axi_req.ar_valid, axi_req.r_ready, axi_req.b_ready}, 64'd1);
            if (axi_req.aw_valid) begin
                if (exp_aw.size() == 0) begin
                    flag("aw_unexpected");
                end else begin
                    check("aw_addr", axi_req.aw.addr, exp_aw[0].addr);
                    check("aw_len", axi_req.aw.len, exp_aw[0].len);
                    check("aw_size", axi_req.aw.size, exp_aw[0].size);
                    check("aw_attr", {axi_req.aw.id, axi_req.aw.burst, axi_req.aw.lock, axi_req.aw.cache,
                                      axi_req.aw.prot, axi_req.aw.qos, axi_req.aw.atop},
                          {2'b00, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 6'h0});
                    if (aw_ready_tb) begin
                        void'(exp_aw.pop_front());
                        aw_cnt++;
                    end
                end
            end
            if (axi_req.w_valid) begin
                if (exp_w.size() == 0) begin
                    flag("w_unexpected");
                end else begin
                    check("w_data", axi_req.w.data, exp_w[0].data);
                    check("w_strb", axi_req.w.strb, exp_w[0].strb);
                    check("w_last", axi_req.w.last, exp_w[0].last);
                    if (w_ready_tb) void'(exp_w.pop_front());
                end
            end
            if (rsp.p_valid && req.p_ready) begin
                if (exp_p.size() == 0) begin
                    flag("p_unexpected");
                end else begin
                    check("p_rsp", {rsp.p.data, rsp.p.error}, exp_p.pop_front());
                end
            end
        end
    end

    // B responder: one B per completed AW handshake, limited by b_allow.
    always @(posedge clk) begin
        #1;
        if (b_sent < aw_cnt && b_sent < b_allow) begin
            b_valid_tb = 1'b1;
            b_resp_tb  = b_resp_sel;
            b_sent++;
        end else begin
            b_valid_tb = 1'b0;
        end
    end

    task automatic exp_run(input logic [31:0] addr, input int n, input logic [2:0] size,
                           input logic [63:0] dbase, input logic [7:0] strb);
        aw_exp_t a;
        w_exp_t  w;
        a.addr = addr; a.len = 8'(n - 1); a.size = size;
        exp_aw.push_back(a);
        for (int i = 0; i < n; i++) begin
            w.data = dbase + 64'(i); w.strb = strb; w.last = (i == n - 1);
            exp_w.push_back(w);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [63:0] data,
                      input logic [7:0] strb, input logic [2:0] size);
        int n;
        req.q.addr = addr; req.q.data = data; req.q.strb = strb; req.q.size = size;
        req.q.write = 1'b1; req.q.amo = 4'h0; req.q_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp.q_ready && n < 300);
        if (!rsp.q_ready) check("wr_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req.q_valid = 1'b0;
    endtask

    task automatic run_beats(input logic [31:0] addr, input int n, input logic [2:0] size,
                             input logic [63:0] dbase, input logic [7:0] strb);
        for (int i = 0; i < n; i++)
            wr(addr + (32'(i) << size), dbase + 64'(i), strb, size);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 500);
        check(name, busy, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req = '0; req.p_ready = 1'b1; clear_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_aw_valid", axi_req.aw_valid, 64'd0);
        check("rst_w_valid", axi_req.w_valid, 64'd0);
        check("rst_p_valid", rsp.p_valid, 64'd0);
        check("rst_busy_err", {busy, err}, 64'd0);
        check("rst_tieoff", {axi_req.ar_valid, axi_req.r_ready, axi_req.b_ready}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full 16-beat burst.
        exp_run(32'h1000, 16, 3'd3, 64'hA000_0000_0000_0000, 8'hFF);
        run_beats(32'h1000, 16, 3'd3, 64'hA000_0000_0000_0000, 8'hFF);
        wait_idle("t1_idle");

        // Non-contiguous beat closes the run.
        exp_run(32'h2000, 3, 3'd3, 64'hB000_0000_0000_0000, 8'hFF);
        exp_run(32'h3000, 1, 3'd3, 64'hB100_0000_0000_0000, 8'hFF);
        run_beats(32'h2000, 3, 3'd3, 64'hB000_0000_0000_0000, 8'hFF);
        wr(32'h3000, 64'hB100_0000_0000_0000, 8'hFF, 3'd3);
        wait_idle("t2_idle");

        // 4KiB boundary splits the run.
        exp_run(32'h0FF0, 2, 3'd3, 64'hC000_0000_0000_0000, 8'h0F);
        exp_run(32'h1000, 1, 3'd3, 64'hC100_0000_0000_0000, 8'h0F);
        run_beats(32'h0FF0, 2, 3'd3, 64'hC000_0000_0000_0000, 8'h0F);
        wr(32'h1000, 64'hC100_0000_0000_0000, 8'h0F, 3'd3);
        wait_idle("t3_idle");

        // Timeout flush of an unaligned single beat; AW stalled for 5 cycles.
        aw_ready_tb = 1'b0;
        exp_run(32'h4004, 1, 3'd2, 64'hD000_0000_0000_0000, 8'h3C);
        wr(32'h4006, 64'hD000_0000_0000_0000, 8'h3C, 3'd2);
        n = 0;
        do begin @(negedge clk); n++; end while (!axi_req.aw_valid && n < 100);
        check("t4_timeout_latency", 64'(n), 64'd17);
        repeat (5) @(negedge clk);
        check("t4_aw_held", axi_req.aw_valid, 64'd1);
        @(posedge clk); #1;
        aw_ready_tb = 1'b1;
        wait_idle("t4_idle");

        // Outstanding limit, SLVERR and error clear.
        b_allow = aw_cnt;
        for (int k = 0; k < 4; k++) begin
            exp_run(32'h6000 + 32'(k) * 32'h100, 1, 3'd3, 64'hE000_0000_0000_0000 + 64'(k), 8'hFF);
            wr(32'h6000 + 32'(k) * 32'h100, 64'hE000_0000_0000_0000 + 64'(k), 8'hFF, 3'd3);
        end
        exp_run(32'h6400, 1, 3'd3, 64'hE000_0000_0000_0004, 8'hFF);
        req.q.addr = 32'h6400; req.q.data = 64'hE000_0000_0000_0004; req.q.strb = 8'hFF;
        req.q.size = 3'd3; req.q.write = 1'b1; req.q_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp.q_ready) n++;
        end
        check("t5_blocked_ready_cycles", 64'(n), 64'd0);
        check("t5_no_err_yet", err, 64'd0);
        b_resp_sel = 2'b10;
        b_allow = b_sent + 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp.q_ready && n < 100);
        check("t5_ready_after_b", rsp.q_ready, 64'd1);
        @(posedge clk); #1;
        req.q_valid = 1'b0;
        @(negedge clk);
        check("t5_err_set", err, 64'd1);
        @(posedge clk); #1;
        b_resp_sel = 2'b00;
        b_allow = 1000000;
        wait_idle("t5_idle");
        check("t5_err_sticky", err, 64'd1);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        @(negedge clk);
        check("t5_err_cleared", err, 64'd0);
        @(posedge clk); #1;

        // Read request gets a one-cycle error response.
        exp_p.push_back({64'd0, 1'b1});
        req.q.addr = 32'h7000; req.q.write = 1'b0; req.q_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp.q_ready && n < 50);
        check("t6_rd_ready", rsp.q_ready, 64'd1);
        @(posedge clk); #1;
        req.q_valid = 1'b0;
        @(negedge clk);
        check("t6_p_valid", rsp.p_valid, 64'd1);
        @(negedge clk);
        check("t6_p_drop", rsp.p_valid, 64'd0);
        @(posedge clk); #1;

        // Reset during a stalled W burst.
        b_allow = aw_cnt;
        w_ready_tb = 1'b0;
        exp_run(32'h5000, 1, 3'd3, 64'hF000_0000_0000_0000, 8'hFF);
        exp_aw[0].len = 8'd1;
        exp_w[0].last = 1'b0;
        run_beats(32'h5000, 2, 3'd3, 64'hF000_0000_0000_0000, 8'hFF);
        n = 0;
        do begin @(negedge clk); n++; end while (!axi_req.w_valid && n < 100);
        check("t7_in_w", axi_req.w_valid, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valids", {axi_req.aw_valid, axi_req.w_valid, rsp.p_valid}, 64'd0);
        check("t7_rst_busy", busy, 64'd0);
        exp_w.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w_ready_tb = 1'b1;
        repeat (30) @(negedge clk);
        check("t7_busy_after", busy, 64'd0);

        check("end_aw_queue", 64'(exp_aw.size()), 64'd0);
        check("end_w_queue", 64'(exp_w.size()), 64'd0);
        check("end_p_queue", 64'(exp_p.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
